icache_read_responder: RTL and testbench
========================================

// Module: icache_read_responder
// PURPOSE
//  Cache-side responder for the fetcher's read request interface (address/read_enable -> read_data/data_valid).
//  Direct-mapped, read-only instruction cache; services hits from local arrays, refills misses via a burst memory port.
//  Sits between the instruction fetcher and the memory/bus adapter; one outstanding request at a time.
// PARAMETERS
//  ADDR_WIDTH   64   byte address width
//  DATA_WIDTH   64   instruction word width returned per request (8 bytes)
//  LINE_WORDS   8    words per cache line (line = 64 B); power of two
//  NUM_SETS     64   number of lines (direct-mapped); power of two
// PORTS
//  clk               in   1           clock
//  reset             in   1           synchronous, active-high reset
//  address           in   ADDR_WIDTH  requested byte address; bits [2:0] ignored
//  read_enable       in   1           request valid; sampled only in IDLE
//  flush             in   1           invalidate-all request (pulse or level)
//  read_data         out  DATA_WIDTH  returned word; valid only while data_valid=1
//  data_valid        out  1           one-cycle pulse, response complete
//  mem_req_valid     out  1           line refill request
//  mem_req_addr      out  ADDR_WIDTH  line-aligned refill address (low log2(LINE_WORDS)+3 bits zero)
//  mem_req_ready     in   1           memory accepts request when valid&ready
//  mem_rdata_valid   in   1           refill beat valid
//  mem_rdata         in   DATA_WIDTH  refill beat data, word 0 first, ascending
//  mem_rdata_last    in   1           marks final beat of line
// BEHAVIOUR
//  Address split: offset [2:0] ignored; word = next log2(LINE_WORDS) bits; index = next log2(NUM_SETS); tag = rest.
//  Reset: state IDLE; all valid bits 0; data_valid=0, read_data=0, mem_req_valid=0, mem_req_addr=0; beat count 0; flush_pending=0.
//  States: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
//   IDLE: flush_pending -> clear all valid bits this cycle, stay IDLE (priority over request).
//         else read_enable=1 -> latch address, go LOOKUP. else stay.
//   LOOKUP: read tag/valid/data at latched index. hit -> RESPOND with word captured. miss -> MISS_REQ.
//   MISS_REQ: mem_req_valid=1, mem_req_addr=line base; hold until mem_req_ready=1, then REFILL.
//   REFILL: each mem_rdata_valid beat writes word[beat_cnt], beat_cnt++; beat equal to requested word captured to read_data.
//           on beat with mem_rdata_last: write tag, set valid, beat_cnt<=0, go RESPOND.
//   RESPOND: data_valid=1 exactly one cycle, read_data held; next state IDLE.
//  Latency (read_enable sampled in cycle 0): hit -> data_valid in cycle 2; miss -> 1 cycle after last-beat cycle.
//  Handshake: requester holds address stable while read_enable=1 until data_valid; requester must drop read_enable
//   in the cycle data_valid is seen, else IDLE re-accepts it as a new request.
//  read_data outside RESPOND holds last value (not cleared); data_valid is the only qualifier.
//  Flush: sampled every cycle into flush_pending; applied only in IDLE; an in-flight refill completes and is returned,
//   then its line is invalidated by the pending flush. flush and read_enable together in IDLE -> flush first, request next cycle.
//  Beat count: width log2(LINE_WORDS); mem_rdata_last is authoritative; a beat count mismatch is a protocol error (bench asserts).
//  mem_rdata_valid outside REFILL ignored. Reset mid-refill -> IDLE, line stays invalid, later stray beats ignored.
//  Same-index replacement: refill overwrites tag/data unconditionally (no write-back, read-only).
// STRUCTURE
//  icache_pkg: state enum icache_state_t; localparams OFFSET_BITS=3, WORD_BITS, INDEX_BITS, TAG_BITS; address field functions.
//  Sub-module icache_line_store: tag+valid array and data array (NUM_SETS x LINE_WORDS x DATA_WIDTH); one read port
//   (registered), one word-write port, tag-write/valid-set port, valid-clear-all port.
//  Top holds FSM, latched request, beat counter, flush_pending, memory-port drive.
// TESTING
//  1 Cold miss: read_enable @0x1000 -> mem_req_addr=0x1000; 8 beats 0xA0..0xA7 -> read_data=0xA0, data_valid 1 cycle.
//  2 Hit: then @0x1018 -> no mem_req_valid; data_valid in cycle 2 with read_data=0xA3.
//  3 Conflict: @0x1000+NUM_SETS*64 (0x2000) -> refill, then @0x1000 misses again (line evicted).
//  4 Backpressure: mem_req_ready low 5 cycles, beats with gaps -> mem_req_addr stable, correct word, one data_valid.
//  5 Flush mid-refill: flush during REFILL of 0x3000 -> response still returned; next @0x3000 misses.
//  6 Reset mid-refill after 3 beats -> outputs at reset values; @same line refetches; stray beats ignored.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default geometry and address-field width helpers.
`default_nettype none

package icache_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_NUM_SETS   = 64;
  localparam int OFFSET_BITS    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_RESPOND  = 3'd4
  } icache_state_t;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int line_words, input int num_sets);
    return addr_width - OFFSET_BITS - $clog2(line_words) - $clog2(num_sets);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_read_responder_line_store.sv
// Tag/valid and data arrays of the cache with a registered read port,
// a refill word-write port, a tag-write/valid-set port and a clear-all port.
`default_nettype none

module icache_read_responder_line_store #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 8,
  parameter int NUM_SETS   = 64,
  parameter int TAG_BITS   = 52
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NUM_SETS)-1:0]   i_rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_word,
  output logic [TAG_BITS-1:0]           o_rd_tag,
  output logic                          o_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  input  logic                          i_word_we,
  input  logic [$clog2(NUM_SETS)-1:0]   i_wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_word,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic                          i_tag_we,
  input  logic [TAG_BITS-1:0]           i_wr_tag,
  input  logic                          i_clear_all
);

  logic [TAG_BITS-1:0]   r_tag  [NUM_SETS];
  logic [DATA_WIDTH-1:0] r_data [NUM_SETS*LINE_WORDS];
  logic [NUM_SETS-1:0]   r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_clear_all) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (i_word_we) begin
      r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
    end
    if (i_tag_we) begin
      r_tag[i_wr_index] <= i_wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    o_rd_tag  <= r_tag[i_rd_index];
    o_rd_data <= r_data[{i_rd_index, i_rd_word}];
    if (reset) begin
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= r_valid[i_rd_index];
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_read_responder.sv
// Direct-mapped read-only instruction cache responder: serves fetcher reads
// from the line store and refills misses over a burst memory port.
`default_nettype none

module icache_read_responder
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read_enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  data_valid,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_last
);

  localparam int c_word_bits  = word_bits(LINE_WORDS);
  localparam int c_index_bits = index_bits(NUM_SETS);
  localparam int c_tag_bits   = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_SETS);
  localparam int c_line_lsb   = OFFSET_BITS + c_word_bits;
  localparam int c_tag_lsb    = c_line_lsb + c_index_bits;

  icache_state_t                   r_state, w_state_next;
  logic [ADDR_WIDTH-1:OFFSET_BITS] r_addr;
  logic [DATA_WIDTH-1:0]           r_rdata;
  logic [c_word_bits-1:0]          r_beat;
  logic                            r_flush_pending;

  logic                    w_accept, w_hit, w_word_we, w_tag_we, w_clear_all, w_flush_now;
  logic                    w_req_valid, w_dvalid;
  logic [c_tag_bits-1:0]   w_rd_tag;
  logic                    w_rd_valid;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [c_word_bits-1:0]  w_req_word;
  logic                    w_unused_offset;

  assign w_unused_offset = ^address[OFFSET_BITS-1:0];
  assign w_req_word      = r_addr[OFFSET_BITS +: c_word_bits];
  assign w_hit           = w_rd_valid && (w_rd_tag == r_addr[c_tag_lsb +: c_tag_bits]);
  // A flush seen in IDLE wins over a simultaneous request.
  assign w_flush_now     = r_flush_pending | flush;

  // The read port is addressed straight from the request so LOOKUP sees the line next cycle.
  icache_read_responder_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .NUM_SETS   (NUM_SETS),
    .TAG_BITS   (c_tag_bits)
  ) u_line_store (
    .clk         (clk),
    .reset       (reset),
    .i_rd_index  (address[c_line_lsb +: c_index_bits]),
    .i_rd_word   (address[OFFSET_BITS +: c_word_bits]),
    .o_rd_tag    (w_rd_tag),
    .o_rd_valid  (w_rd_valid),
    .o_rd_data   (w_rd_data),
    .i_word_we   (w_word_we),
    .i_wr_index  (r_addr[c_line_lsb +: c_index_bits]),
    .i_wr_word   (r_beat),
    .i_wr_data   (mem_rdata),
    .i_tag_we    (w_tag_we),
    .i_wr_tag    (r_addr[c_tag_lsb +: c_tag_bits]),
    .i_clear_all (w_clear_all)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_clear_all  = 1'b0;
    w_req_valid  = 1'b0;
    w_word_we    = 1'b0;
    w_tag_we     = 1'b0;
    w_dvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_now) begin
          w_clear_all = 1'b1;
        end else if (read_enable) begin
          w_accept     = 1'b1;
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP:   w_state_next = w_hit ? ST_RESPOND : ST_MISS_REQ;
      ST_MISS_REQ: begin
        w_req_valid = 1'b1;
        if (mem_req_ready) w_state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_rdata_valid) begin
          w_word_we = 1'b1;
          if (mem_rdata_last) begin
            w_tag_we     = 1'b1;
            w_state_next = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        w_dvalid     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr          <= '0;
      r_rdata         <= '0;
      r_beat          <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_accept) r_addr <= address[ADDR_WIDTH-1:OFFSET_BITS];
      if (r_state == ST_LOOKUP && w_hit) r_rdata <= w_rd_data;
      if (w_word_we) begin
        if (r_beat == w_req_word) r_rdata <= mem_rdata;
        r_beat <= mem_rdata_last ? '0 : r_beat + 1'b1;
      end
      // Any pending flush is consumed by the IDLE cycle that applies it.
      r_flush_pending <= (r_state == ST_IDLE) ? 1'b0 : (r_flush_pending | flush);
    end
  end

  assign read_data     = r_rdata;
  assign data_valid    = w_dvalid;
  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = w_req_valid ? {r_addr[ADDR_WIDTH-1:c_line_lsb], {c_line_lsb{1'b0}}} : '0;

endmodule

`default_nettype wire

// File: tb/tb_icache_read_responder.sv
// Randomized self-checking bench for icache_read_responder against a
// line-level cache model and a backing memory whose contents change by epoch.
`default_nettype none

module tb_icache_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address;
  logic        read_enable, flush;
  logic [63:0] read_data;
  logic        data_valid, mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready, mem_rdata_valid, mem_rdata_last;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int epoch    = 0;

  bit          mvalid [64];
  logic [63:0] mtag   [64];
  logic [63:0] mdata  [64][8];

  icache_read_responder dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .read_enable     (read_enable),
    .flush           (flush),
    .read_data       (read_data),
    .data_valid      (data_valid),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .mem_rdata_last  (mem_rdata_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memval(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ {32'(epoch), 32'h5A5A_0000};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch: predicts hit/miss from the model, plays the memory side on a miss,
  // optionally flushes alongside the request or mid-refill, or resets after abort_after beats.
  task automatic transact(input logic [63:0] a, input int stall, input int gapmax,
                          input bit flush_mid, input bit flush_with_req, input int abort_after);
    int          idx, wrd, cyc, nb;
    logic [63:0] tg, base, exp;
    bit          hit, did_flush;
    idx  = int'((a >> 6) % 64);
    wrd  = int'((a >> 3) % 8);
    tg   = a >> 12;
    base = a & ~64'h3F;
    did_flush = 1'b0;
    if (flush_with_req) clear_model();
    hit = mvalid[idx] && (mtag[idx] == tg);
    address = a; read_enable = 1'b1; flush = flush_with_req;
    cyc = 0;
    do begin
      tick();
      flush = 1'b0;
      cyc++;
    end while (!data_valid && !mem_req_valid && cyc < 20);
    check("start_latency", 64'(cyc), 64'(2 + int'(flush_with_req)));
    check("miss_flag", 64'(mem_req_valid), 64'(!hit));
    if (hit) begin
      exp = mdata[idx][wrd];
    end else begin
      check("req_addr", mem_req_addr, base);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("req_hold", mem_req_valid ? mem_req_addr : 64'hDEAD, base);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("req_drop", 64'(mem_req_valid), 64'h0);
      nb = (abort_after >= 0) ? abort_after : 8;
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(gapmax, 0)) tick();
        mem_rdata_valid = 1'b1;
        mem_rdata       = memval(base + 64'(8 * b));
        mem_rdata_last  = (b == 7);
        mdata[idx][b]   = mem_rdata;
        if (flush_mid && b == 2) begin
          flush = 1'b1; did_flush = 1'b1;
        end
        tick();
        mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0; flush = 1'b0;
        if (b != 7) check("no_early_dv", 64'(data_valid), 64'h0);
      end
      if (abort_after >= 0) begin
        reset = 1'b1; read_enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_dv", 64'(data_valid), 64'h0);
        check("rst_rdata", read_data, 64'h0);
        check("rst_req_valid", 64'(mem_req_valid), 64'h0);
        check("rst_req_addr", mem_req_addr, 64'h0);
        clear_model();
        for (int b = nb; b < 8; b++) begin
          mem_rdata_valid = 1'b1;
          mem_rdata       = memval(base + 64'(8 * b));
          mem_rdata_last  = (b == 7);
          tick();
          check("stray_dv", 64'(data_valid), 64'h0);
          check("stray_req", 64'(mem_req_valid), 64'h0);
        end
        mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0;
        return;
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      exp         = mdata[idx][wrd];
    end
    check("dv", 64'(data_valid), 64'h1);
    check("rdata", read_data, exp);
    read_enable = 1'b0;
    tick();
    check("dv_pulse", 64'(data_valid), 64'h0);
    check("rdata_hold", read_data, exp);
    if (did_flush) begin
      clear_model();
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int          sel, mode;
    reset = 1'b1; address = '0; read_enable = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0; mem_rdata = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dv", 64'(data_valid), 64'h0);
    check("reset_rdata", read_data, 64'h0);
    check("reset_req_valid", 64'(mem_req_valid), 64'h0);
    check("reset_req_addr", mem_req_addr, 64'h0);
    reset = 1'b0;
    tick();

    transact(64'h1000, 0, 0, 1'b0, 1'b0, -1);   // cold miss
    transact(64'h1018, 0, 0, 1'b0, 1'b0, -1);   // hit on the same line
    transact(64'h2000, 0, 0, 1'b0, 1'b0, -1);   // same index, evicts 0x1000
    transact(64'h1000, 0, 0, 1'b0, 1'b0, -1);
    transact(64'h1040, 5, 3, 1'b0, 1'b0, -1);   // backpressure and beat gaps
    transact(64'h3000, 0, 1, 1'b1, 1'b0, -1);   // flush during refill
    transact(64'h3000, 0, 0, 1'b0, 1'b0, -1);
    transact(64'h3008, 0, 0, 1'b0, 1'b1, -1);   // flush together with request
    transact(64'h1080, 0, 0, 1'b0, 1'b0, 3);    // reset after three beats
    transact(64'h1088, 0, 0, 1'b0, 1'b0, -1);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom % 7);
      case (sel)
        0:       a = 64'h1000;
        1:       a = 64'h2000;
        2:       a = 64'h3000;
        3:       a = 64'h1040;
        4:       a = 64'hFFFF_FFFF_0000_0080;
        default: a = {$urandom, $urandom};
      endcase
      a = (a & ~64'h3F) | 64'($urandom % 64);
      if ($urandom % 8 == 0) epoch++;
      mode = int'($urandom % 16);
      transact(a, int'($urandom % 6), int'($urandom % 3), mode == 0, mode == 1,
               (mode == 2) ? int'($urandom % 7) : -1);
      repeat ($urandom % 3) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
